mmix_mem_responder: RTL and testbench
=====================================

Name: mmix_mem_responder

Overview:
- Responder end of the CPU memory request interface: mem_address, mem_datasize, mem_read, mem_write, mem_writedata, mem_readdata and mem_done.
- Accepts one sized MMIX access at a time, aligns it big-endian, and splits it into 1–4 beats on a 16-bit Avalon-style slave bus (SDRAM/SRAM controller side).
- Assembles read data, then pulses mem_done for one cycle.
- Sits between the cpu memory port and the board memory controller.

Parameters:
- SADDR_W, 23, width of the 16-bit-word address on the slave bus (2^SADDR_W words).

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- mem_address  in  64  byte address from CPU
- mem_datasize  in  2  0 byte, 1 wyde, 2 tetra, 3 octa
- mem_read  in  1  read request level
- mem_write  in  1  write request level
- mem_writedata  in  64  write data, right-aligned
- mem_readdata  out  64  read data, right-aligned, zero-extended
- mem_done  out  1  one-cycle completion pulse
- mem_error  out  1  sticky out-of-range flag (see Optional Feature)
- s_address  out  SADDR_W  word address
- s_byteen  out  2  bit1 = lane [15:8] (even byte), bit0 = lane [7:0] (odd byte)
- s_read  out  1  slave read strobe
- s_write  out  1  slave write strobe
- s_writedata  out  16  slave write data
- s_readdata  in  16  slave read data, valid when s_read=1 and s_waitrequest=0
- s_waitrequest  in  1  slave stall
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: mem_readdata=0, mem_done=0, mem_error=0, s_read=0, s_write=0, s_address=0, s_byteen=0, s_writedata=0, busy=0, state=IDLE.
- Reset asserted mid-transaction: the current transaction is abandoned at that edge and no mem_done is issued.
- States: IDLE -> BEAT -> DONE -> GAP -> IDLE.
- IDLE: samples requests. If mem_read or mem_write is high, latch the request; mem_read wins if both are high (treated as a read).
  - Aligned address a = mem_address with its low datasize bits cleared (byte: none, wyde: 1, tetra: 2, octa: 3).
  - Beat count n = 1, 1, 2, 4 for byte, wyde, tetra, octa.
  - Go to BEAT with k=0.
- BEAT:
  - Drive s_address = a[SADDR_W:1] + k. Drive s_read or s_write.
  - s_byteen: byte access uses 2'b10 if a[0]=0, else 2'b01. All other sizes use 2'b11.
  - s_writedata:
    - byte: {wd[7:0], wd[7:0]}
    - wyde: wd[15:0]
    - tetra beat k: wd[31-16k -: 16]
    - octa beat k: wd[63-16k -: 16]
  - Strobes and address stay stable while s_waitrequest=1.
  - When s_waitrequest=0, the beat completes. On reads, acc <= {acc[47:0], lane}; for bytes, lane = the selected 8 bits, zero-extended.
  - After the last beat (k=n-1), drop the strobes and go to DONE; otherwise increment k.
- DONE (one cycle): mem_done=1. On reads, mem_readdata = acc, zero-extended to 64 bits. Writes leave mem_readdata unchanged.
- GAP (one cycle): requests are ignored. The initiator deasserts or changes its request in the cycle after mem_done; requests held through GAP are serviced again as new requests.
- mem_readdata holds its value until the next read completes.
- Latency with zero waits, request sampled at T:
  - strobe from T+1
  - 1-beat access: mem_done at T+2
  - tetra: mem_done at T+3
  - octa: mem_done at T+5
  - each wait cycle adds one.
- Address bits above SADDR_W+1 are ignored (memory aliases) unless the Optional Feature is enabled.
- No beat counter wraps. s_address addition stays within the aligned block, because an octa never crosses a 4-word boundary.

Optional Feature:
- MEM_BOUNDS_CHK_EN defined: if any bit of mem_address[63:SADDR_W+1] is set, the request goes IDLE -> DONE directly with no slave strobe.
  - Read returns mem_readdata=0.
  - Write is dropped.
  - mem_error is set and stays set until reset.
- Undefined: no check; mem_error is tied to 0.

Test Plan:
- Octa read at 0x1007, size 3, slave words 0x0123,0x4567,0x89AB,0xCDEF, no waits -> s_address 0x800..0x803, mem_done at T+5, mem_readdata=0x0123456789ABCDEF.
- Byte write at 0x21, wd=0xA5 -> one beat: s_address=0x10, s_byteen=2'b01, s_writedata=0xA5A5, mem_done at T+2.
- Tetra read at 0x40 with s_waitrequest high for 3 cycles on beat 0 -> strobe and address stable throughout, mem_done at T+6, data = {word0, word1}.
- Byte read at 0x41, slave lane 0x12FE -> mem_readdata=0x00000000000000FE. Wyde read of the same word -> 0x12FE.
- Reset pulsed in the second beat of an octa write -> s_write=0 at the next edge, no mem_done; a subsequent wyde read completes normally.
- Request held high through GAP after mem_done -> second access starts in IDLE two cycles after mem_done. With MEM_BOUNDS_CHK_EN and address 0x8000000000000000 -> no strobe, mem_done at T+1, mem_readdata=0, mem_error=1.

Source files
------------

// File: rtl/mmix_mem_responder_if.sv
// CPU memory request port plus the 16-bit Avalon-style slave bus of mmix_mem_responder.
// "slave" is the responder's view; "master" is the view of the CPU/memory environment.
interface mmix_mem_responder_if #(
    parameter int SADDR_W = 23
);
    logic [63:0]        mem_address;
    logic [1:0]         mem_datasize;
    logic               mem_read;
    logic               mem_write;
    logic [63:0]        mem_writedata;
    logic [63:0]        mem_readdata;
    logic               mem_done;
    logic               mem_error;
    logic [SADDR_W-1:0] s_address;
    logic [1:0]         s_byteen;
    logic               s_read;
    logic               s_write;
    logic [15:0]        s_writedata;
    logic [15:0]        s_readdata;
    logic               s_waitrequest;

    modport slave (
        input  mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
        output mem_readdata, mem_done, mem_error,
        output s_address, s_byteen, s_read, s_write, s_writedata,
        input  s_readdata, s_waitrequest
    );

    modport master (
        output mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
        input  mem_readdata, mem_done, mem_error,
        input  s_address, s_byteen, s_read, s_write, s_writedata,
        output s_readdata, s_waitrequest
    );
endinterface

// File: rtl/mmix_mem_responder.sv
// Splits one sized big-endian MMIX access into 1-4 beats on a 16-bit slave bus and assembles reads.
// Define MEM_BOUNDS_CHK_EN to reject addresses above the slave window and raise a sticky mem_error.
module mmix_mem_responder #(
    parameter int SADDR_W = 23
) (
    input  logic                clk,
    input  logic                reset,
    mmix_mem_responder_if.slave bus,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, BEAT, DONE, GAP} state_t;

    state_t           state, state_nxt;
    logic             is_rd;
    logic [1:0]       size;
    logic [SADDR_W:0] addr;
    logic [63:0]      wd;
    logic [1:0]       k;
    logic [63:0]      acc, acc_nxt;
    logic             req, oob, last, beat_ok;

    function automatic logic [1:0] last_beat(input logic [1:0] sz);
        case (sz)
            2'd3:    return 2'd3;
            2'd2:    return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [SADDR_W:0] align_addr(input logic [63:0] a, input logic [1:0] sz);
        logic [SADDR_W:0] r;
        r = a[SADDR_W:0];
        case (sz)
            2'd1:    r[0]   = 1'b0;
            2'd2:    r[1:0] = 2'b00;
            2'd3:    r[2:0] = 3'b000;
            default: ;
        endcase
        return r;
    endfunction

    // Beat k carries the k-th most significant 16 bits of the right-aligned write data.
    function automatic logic [15:0] beat_wdata(input logic [63:0] d, input logic [1:0] sz,
                                               input logic [1:0] kk);
        logic [1:0]  lk;
        logic [5:0]  sh;
        logic [63:0] shifted;
        if (sz == 2'd0) return {d[7:0], d[7:0]};
        lk      = last_beat(sz);
        sh      = {lk - kk, 4'b0000};
        shifted = d >> sh;
        return shifted[15:0];
    endfunction

    function automatic logic [15:0] read_lane(input logic [15:0] rd, input logic [1:0] sz,
                                              input logic a0);
        if (sz != 2'd0) return rd;
        return a0 ? {8'h00, rd[7:0]} : {8'h00, rd[15:8]};
    endfunction

    assign req     = bus.mem_read | bus.mem_write;
    assign last    = (k == last_beat(size));
    assign beat_ok = (state == BEAT) && !bus.s_waitrequest;

    always_comb begin
        state_nxt       = state;
        busy            = (state != IDLE);
        bus.mem_done    = 1'b0;
        bus.s_address   = '0;
        bus.s_byteen    = 2'b00;
        bus.s_read      = 1'b0;
        bus.s_write     = 1'b0;
        bus.s_writedata = 16'h0000;
        acc_nxt         = {acc[47:0], read_lane(bus.s_readdata, size, addr[0])};
        case (state)
            IDLE: begin
                if (req) state_nxt = oob ? DONE : BEAT;
            end
            BEAT: begin
                bus.s_address   = addr[SADDR_W:1] + SADDR_W'(k);
                bus.s_byteen    = (size == 2'd0) ? (addr[0] ? 2'b01 : 2'b10) : 2'b11;
                bus.s_read      = is_rd;
                bus.s_write     = !is_rd;
                bus.s_writedata = beat_wdata(wd, size, k);
                if (!bus.s_waitrequest && last) state_nxt = DONE;
            end
            DONE: begin
                bus.mem_done = 1'b1;
                state_nxt    = GAP;
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state and the visible read result; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            k                <= 2'd0;
            bus.mem_readdata <= 64'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)
                k <= 2'd0;
            else if (beat_ok && !last)
                k <= k + 2'd1;
            if (state == IDLE && req && oob && bus.mem_read)
                bus.mem_readdata <= 64'd0;
            else if (beat_ok && last && is_rd)
                bus.mem_readdata <= acc_nxt;
        end
    end

    // Request capture and read accumulation.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            is_rd <= bus.mem_read;
            size  <= bus.mem_datasize;
            addr  <= align_addr(bus.mem_address, bus.mem_datasize);
            wd    <= bus.mem_writedata;
            acc   <= 64'd0;
        end else if (beat_ok && is_rd) begin
            acc <= acc_nxt;
        end
    end

`ifdef MEM_BOUNDS_CHK_EN
    logic err;

    assign oob = |bus.mem_address[63:SADDR_W+1];

    always_ff @(posedge clk) begin
        if (reset)
            err <= 1'b0;
        else if (state == IDLE && req && oob)
            err <= 1'b1;
    end

    assign bus.mem_error = err;
`else
    // High address bits alias onto the slave window when the bounds check is absent.
    logic unused_addr_hi;

    assign oob            = 1'b0;
    assign unused_addr_hi = |bus.mem_address[63:SADDR_W+1];
    assign bus.mem_error  = 1'b0;
`endif
endmodule

// File: tb/tb_mmix_mem_responder.sv
// Randomized bench for mmix_mem_responder: a word-array slave with random stalls and a
// byte-addressed big-endian reference memory that predicts every access.
module tb_mmix_mem_responder;
    localparam int SADDR_W = 23;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    mmix_mem_responder_if #(.SADDR_W(SADDR_W)) bus ();

    mmix_mem_responder #(.SADDR_W(SADDR_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SADDR_W-1:0] addr;
        logic [1:0]         be;
        logic [15:0]        wdata;
    } beat_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] smem [0:511];
    logic [7:0]  rmem [0:1023];
    beat_t       beats_q[$];
    int          waits_seen = 0;
    int          wait_pct   = 0;
    int          stall_n    = 0;
    bit          force_wait = 1'b0;
    logic [63:0] exp_rd     = 64'd0;
    bit          exp_err    = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [15:0] w);
        smem[idx]         = w;
        rmem[2 * idx]     = w[15:8];
        rmem[2 * idx + 1] = w[7:0];
    endtask

    function automatic logic [63:0] ref_read(input logic [63:0] a, input logic [1:0] sz);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < (1 << sz); i++)
            v = (v << 8) | 64'(rmem[(int'(a[9:0]) + i) % 1024]);
        return v;
    endfunction

    task automatic ref_write(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d);
        int nb;
        nb = 1 << sz;
        for (int i = 0; i < nb; i++)
            rmem[(int'(a[9:0]) + i) % 1024] = d[8 * (nb - 1 - i) +: 8];
    endtask

    // Slave memory: completes beats, injects stalls, and checks the bus holds still while stalled.
    initial begin
        beat_t b;
        beat_t held;
        logic  held_rd, held_wr, stalled;
        int    idx;
        bus.s_waitrequest = 1'b0;
        bus.s_readdata    = 16'h0000;
        forever begin
            @(posedge clk);
            held.addr  = bus.s_address;
            held.be    = bus.s_byteen;
            held.wdata = bus.s_writedata;
            held_rd    = bus.s_read;
            held_wr    = bus.s_write;
            stalled    = (held_rd || held_wr) && bus.s_waitrequest && !reset;
            if ((held_rd || held_wr) && bus.s_waitrequest) waits_seen++;
            if ((held_rd || held_wr) && !bus.s_waitrequest) begin
                b = held;
                beats_q.push_back(b);
                idx = int'(held.addr[8:0]);
                if (held_wr && held.be[1]) smem[idx][15:8] = held.wdata[15:8];
                if (held_wr && held.be[0]) smem[idx][7:0]  = held.wdata[7:0];
            end
            #1;
            if (stalled) begin
                check_eq("stall_addr", 64'(bus.s_address), 64'(held.addr));
                check_eq("stall_ctl", 64'({bus.s_read, bus.s_write, bus.s_byteen}),
                         64'({held_rd, held_wr, held.be}));
                if (held_wr) check_eq("stall_wdata", 64'(bus.s_writedata), 64'(held.wdata));
            end
            if (stall_n > 0 && (bus.s_read || bus.s_write)) begin
                bus.s_waitrequest = 1'b1;
                stall_n--;
            end else begin
                bus.s_waitrequest = force_wait || (int'($urandom_range(99)) < wait_pct);
            end
            bus.s_readdata = smem[bus.s_address[8:0]];
        end
    end

    // One complete access from IDLE back to IDLE; hold keeps the request asserted through GAP.
    task automatic run_access(input logic [63:0] a, input logic [1:0] sz, input bit rd,
                              input logic [63:0] wd, input bit hold, output int lat);
        logic [63:0]        al;
        logic [SADDR_W-1:0] wa;
        logic [1:0]         exp_be;
        bit                 oob;
        int                 n, nb, c, oh;
        al  = a & ~((64'd1 << sz) - 64'd1);
        oob = 1'b0;
`ifdef MEM_BOUNDS_CHK_EN
        oob = |a[63:SADDR_W+1];
`endif
        n  = oob ? 0 : (sz == 2'd3 ? 4 : (sz == 2'd2 ? 2 : 1));
        nb = 1 << sz;
        check_eq("idle_busy", 64'(busy), 64'd0);
        beats_q.delete();
        waits_seen        = 0;
        bus.mem_address   = a;
        bus.mem_datasize  = sz;
        bus.mem_read      = rd;
        bus.mem_write     = rd ? 1'($urandom_range(1)) : 1'b1;
        bus.mem_writedata = wd;
        @(posedge clk);
        #1;
        c = 0;
        while (!bus.mem_done && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (!bus.mem_done) check_eq("done_timeout", 64'd0, 64'd1);
        lat = c + 1;
        check_eq("latency", 64'(lat), 64'(n + 1 + waits_seen));
        if (oob) begin
            exp_err = 1'b1;
            if (rd) exp_rd = 64'd0;
        end else if (rd) begin
            exp_rd = ref_read(al, sz);
        end else begin
            ref_write(al, sz, wd);
        end
        check_eq("readdata", bus.mem_readdata, exp_rd);
        check_eq("beat_count", 64'(beats_q.size()), 64'(n));
        exp_be = (sz == 2'd0) ? (al[0] ? 2'b01 : 2'b10) : 2'b11;
        for (int i = 0; i < beats_q.size() && i < n; i++) begin
            wa = al[SADDR_W:1] + SADDR_W'(i);
            check_eq("s_address", 64'(beats_q[i].addr), 64'(wa));
            check_eq("s_byteen", 64'(beats_q[i].be), 64'(exp_be));
            if (!rd) begin
                oh = 2 * i - int'(al[0]);
                if (exp_be[1]) check_eq("wr_hi", 64'(beats_q[i].wdata[15:8]), 64'(wd[8 * (nb - 1 - oh) +: 8]));
                if (exp_be[0]) check_eq("wr_lo", 64'(beats_q[i].wdata[7:0]), 64'(wd[8 * (nb - 2 - oh) +: 8]));
            end
        end
        @(posedge clk);
        #1;
        check_eq("done_pulse", 64'(bus.mem_done), 64'd0);
        check_eq("gap_busy", 64'(busy), 64'd1);
        if (!hold) begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("back_idle", 64'(busy), 64'd0);
        check_eq("mem_error", 64'(bus.mem_error), 64'(exp_err));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [63:0] wd, a;
        logic [1:0]  sz;
        bit          rd;
        reset             = 1'b1;
        bus.mem_address   = 64'd0;
        bus.mem_datasize  = 2'd0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_writedata = 64'd0;
        for (int i = 0; i < 512; i++) set_word(i, 16'($urandom));
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_readdata", bus.mem_readdata, 64'd0);
        check_eq("rst_done", 64'(bus.mem_done), 64'd0);
        check_eq("rst_error", 64'(bus.mem_error), 64'd0);
        check_eq("rst_strobes", 64'({bus.s_read, bus.s_write, bus.s_byteen}), 64'd0);
        check_eq("rst_s_address", 64'(bus.s_address), 64'd0);
        check_eq("rst_s_writedata", 64'(bus.s_writedata), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Octa read from an unaligned address: aligns down to 0x1000.
        set_word(0, 16'h0123); set_word(1, 16'h4567); set_word(2, 16'h89AB); set_word(3, 16'hCDEF);
        run_access(64'h1007, 2'd3, 1'b1, 64'd0, 1'b0, lat);
        check_eq("octa_lat", 64'(lat), 64'd5);
        check_eq("octa_val", bus.mem_readdata, 64'h0123456789ABCDEF);

        // Byte write to an odd address: low lane only, byte duplicated.
        run_access(64'h21, 2'd0, 1'b0, 64'hA5, 1'b0, lat);
        check_eq("bw_lat", 64'(lat), 64'd2);
        check_eq("bw_addr", 64'(beats_q[0].addr), 64'h10);
        check_eq("bw_be", 64'(beats_q[0].be), 64'b01);
        check_eq("bw_wdata", 64'(beats_q[0].wdata), 64'hA5A5);
        check_eq("bw_keep_rd", bus.mem_readdata, 64'h0123456789ABCDEF);

        // Tetra read stalled three cycles on the first beat.
        set_word(32, 16'h1357); set_word(33, 16'h2468);
        stall_n = 3;
        run_access(64'h40, 2'd2, 1'b1, 64'd0, 1'b0, lat);
        check_eq("tetra_lat", 64'(lat), 64'd6);
        check_eq("tetra_val", bus.mem_readdata, 64'h13572468);

        // Byte and wyde reads of the same word.
        set_word(32, 16'h12FE);
        run_access(64'h41, 2'd0, 1'b1, 64'd0, 1'b0, lat);
        check_eq("byte_val", bus.mem_readdata, 64'hFE);
        run_access(64'h40, 2'd1, 1'b1, 64'd0, 1'b0, lat);
        check_eq("wyde_val", bus.mem_readdata, 64'h12FE);

        // Reset during the stalled second beat of an octa write.
        wd                = {$urandom, $urandom};
        bus.mem_address   = 64'h100;
        bus.mem_datasize  = 2'd3;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b1;
        bus.mem_writedata = wd;
        @(posedge clk);
        #1;
        check_eq("rst_beat0_wr", 64'(bus.s_write), 64'd1);
        #1 force_wait = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_beat1_addr", 64'(bus.s_address), 64'h81);
        #1;
        reset         = 1'b1;
        bus.mem_write = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_mid_write", 64'(bus.s_write), 64'd0);
        check_eq("rst_mid_done", 64'(bus.mem_done), 64'd0);
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        check_eq("rst_mid_rd", bus.mem_readdata, 64'd0);
        #1;
        reset      = 1'b0;
        force_wait = 1'b0;
        exp_rd     = 64'd0;
        exp_err    = 1'b0;
        ref_write(64'h100, 2'd1, {48'd0, wd[63:48]});
        repeat (4) begin
            @(posedge clk);
            #1;
            check_eq("rst_no_done", 64'(bus.mem_done), 64'd0);
        end
        run_access(64'h100, 2'd1, 1'b1, 64'd0, 1'b0, lat);
        check_eq("rst_wyde", bus.mem_readdata, 64'(wd[63:48]));

        // Request held through GAP is serviced a second time.
        run_access(64'h88, 2'd2, 1'b1, 64'd0, 1'b1, lat);
        run_access(64'h88, 2'd2, 1'b1, 64'd0, 1'b0, lat);
        check_eq("hold_val", bus.mem_readdata, ref_read(64'h88, 2'd2));

        // Address with only the top bit set: rejected or aliased depending on the build.
        run_access(64'h8000000000000000, 2'd3, 1'b1, 64'd0, 1'b0, lat);
`ifdef MEM_BOUNDS_CHK_EN
        check_eq("oob_lat", 64'(lat), 64'd1);
        check_eq("oob_val", bus.mem_readdata, 64'd0);
        check_eq("oob_err", 64'(bus.mem_error), 64'd1);
`else
        check_eq("alias_lat", 64'(lat), 64'd5);
        check_eq("alias_err", 64'(bus.mem_error), 64'd0);
`endif

        // Random traffic with random stalls.
        wait_pct = 30;
        for (int t = 0; t < 200; t++) begin
            a = {40'd0, 14'($urandom), 10'($urandom)};
            if ($urandom_range(7) == 0) a[63:24] = 40'($urandom) | 40'h1;
            sz = 2'($urandom_range(3));
            rd = 1'($urandom_range(1));
            wd = {$urandom, $urandom};
            run_access(a, sz, rd, wd, 1'b0, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
